// File: rtl/adc_sample_decimator.sv
// Block-averaging decimator for the ADC1410 ch1/ch2 sample stream: sums 2^k samples per channel
// and presents one floor-averaged pair per window on a valid/ready output with sticky overrun.
module adc_sample_decimator #(
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned DECIM_LOG2_MAX = 8
) (
  input  logic                 i_sys_clock,
  input  logic                 i_reset,
  input  logic                 i_init_done,
  input  logic                 i_enable,
  input  logic [3:0]           i_decim_log2,
  input  logic                 i_sample_valid,
  input  logic [DATA_SIZE-1:0] i_data_ch1,
  input  logic [DATA_SIZE-1:0] i_data_ch2,
  output logic [DATA_SIZE-1:0] o_data_ch1,
  output logic [DATA_SIZE-1:0] o_data_ch2,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overrun,
  input  logic                 i_clear_overrun
);

  localparam int unsigned AccW = DATA_SIZE + DECIM_LOG2_MAX;
  localparam int unsigned CntW = (DECIM_LOG2_MAX > 0) ? DECIM_LOG2_MAX : 1;
  localparam logic [3:0]  KMax = 4'(DECIM_LOG2_MAX);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e                state_q, state_d;
  logic [3:0]            k_eff_q, k_eff_d;
  logic [CntW-1:0]       count_q, count_d;
  logic signed [AccW-1:0] acc1_q, acc1_d;
  logic signed [AccW-1:0] acc2_q, acc2_d;
  logic [DATA_SIZE-1:0]  data1_q, data1_d;
  logic [DATA_SIZE-1:0]  data2_q, data2_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  logic                  run;
  logic [3:0]            k_clamped;
  logic [CntW-1:0]       win_last;
  logic signed [AccW-1:0] sum1, sum2;
  logic signed [AccW-1:0] avg1, avg2;
  logic                  win_done;
  logic                  load;
  logic                  drop;

  assign run       = i_init_done & i_enable;
  assign k_clamped = (i_decim_log2 > KMax) ? KMax : i_decim_log2;

  // Last count index of the window: 2^k_eff - 1, i.e. the low k_eff bits set.
  always_comb begin
    win_last = '0;
    for (int i = 0; i < int'(CntW); i++) begin
      win_last[i] = (i < int'(k_eff_q));
    end
  end

  assign sum1 = acc1_q + {{DECIM_LOG2_MAX{i_data_ch1[DATA_SIZE-1]}}, i_data_ch1};
  assign sum2 = acc2_q + {{DECIM_LOG2_MAX{i_data_ch2[DATA_SIZE-1]}}, i_data_ch2};
  assign avg1 = sum1 >>> k_eff_q;
  assign avg2 = sum2 >>> k_eff_q;

  always_comb begin
    state_d  = state_q;
    k_eff_d  = k_eff_q;
    count_d  = count_q;
    acc1_d   = acc1_q;
    acc2_d   = acc2_q;
    win_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StAccum;
          k_eff_d = k_clamped;
          count_d = '0;
          acc1_d  = '0;
          acc2_d  = '0;
        end
      end
      StAccum: begin
        if (!run) begin
          // Partial window is discarded; any pending output pair is left alone.
          state_d = StIdle;
          count_d = '0;
          acc1_d  = '0;
          acc2_d  = '0;
        end else if (i_sample_valid) begin
          if (count_q == win_last) begin
            win_done = 1'b1;
            k_eff_d  = k_clamped;
            count_d  = '0;
            acc1_d   = '0;
            acc2_d   = '0;
          end else begin
            count_d = count_q + 1'b1;
            acc1_d  = sum1;
            acc2_d  = sum2;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A finished window loads only if the output slot is free or being drained this cycle.
  assign load = win_done & (~valid_q | i_ready);
  assign drop = win_done & valid_q & ~i_ready;

  always_comb begin
    data1_d   = data1_q;
    data2_d   = data2_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      data1_d = avg1[DATA_SIZE-1:0];
      data2_d = avg2[DATA_SIZE-1:0];
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end else if (i_clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      k_eff_q   <= '0;
      count_q   <= '0;
      acc1_q    <= '0;
      acc2_q    <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_eff_q   <= k_eff_d;
      count_q   <= count_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data_ch1 = data1_q;
  assign o_data_ch2 = data2_q;
  assign o_valid    = valid_q;
  assign o_overrun  = overrun_q;

endmodule
